// File: rtl/nand_phy_pkg.sv
// Shared NAND PHY definitions: sequencer state encoding and default
// preamble/postamble cycle counts, used by the write- and read-side sequencers.
package nand_phy_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PRE   = 2'd1;
    localparam logic [1:0] ST_BURST = 2'd2;
    localparam logic [1:0] ST_POST  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_PRE   = ST_PRE,
        S_BURST = ST_BURST,
        S_POST  = ST_POST
    } seq_state_e;

    // Default tWPRE / tWPST expressed in clk0 cycles
    localparam int unsigned NAND_TWPRE_CYC = 32'd2;
    localparam int unsigned NAND_TWPST_CYC = 32'd2;

    // Width of the preamble/postamble phase counter
    localparam int unsigned PHASE_W = 32'd4;

endpackage

// File: rtl/nand_phy_dqs_wr_seq.sv
// NAND DDR write-burst sequencer feeding the DQS/DQ IOBs.
// Walks IDLE -> PRE -> BURST -> POST -> IDLE, driving the DQS/DQ tristates,
// the DQS toggle enable and the write-FIFO pop. All outputs are registered and
// decoded from the next state so they line up with the state register.
// Optional build macro NAND_WR_BURST_CNT_EN adds a 16-bit completed-burst counter
// output (burst_cnt) that steps on every done pulse.
module nand_phy_dqs_wr_seq
    import nand_phy_pkg::*;
#(
    parameter int unsigned PRE_CYCLES  = NAND_TWPRE_CYC,
    parameter int unsigned POST_CYCLES = NAND_TWPST_CYC,
    parameter int unsigned LEN_W       = 32'd16
) (
    input  logic             clk0,
    input  logic             rst0,
    input  logic             wr_start,
    input  logic [LEN_W-1:0] wr_len,
    input  logic             wr_abort,
    output logic             busy,
    output logic             done,
    output logic             wdata_rd_en,
    output logic             dqs_oe_n,
    output logic             dqs_rst_n,
`ifdef NAND_WR_BURST_CNT_EN
    output logic [15:0]      burst_cnt,
`endif
    output logic             dq_oe_n
);

    localparam logic [PHASE_W-1:0] PRE_LOAD  = PHASE_W'(PRE_CYCLES - 32'd1);
    localparam logic [PHASE_W-1:0] POST_LOAD = PHASE_W'(POST_CYCLES - 32'd1);
    localparam logic [LEN_W-1:0]   LEN_ZERO  = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0]   LEN_ONE   = LEN_W'(32'd1);

    seq_state_e         state_r, state_s;
    logic [LEN_W-1:0]   word_cnt_r, word_cnt_s;
    logic [PHASE_W-1:0] phase_cnt_r, phase_cnt_s;
    logic               done_s;
    logic               busy_s, rd_en_s, dqs_oe_n_s, dqs_rst_n_s, dq_oe_n_s;

    // Next-state and counter update for the burst sequencer
    always_comb begin
        state_s     = state_r;
        word_cnt_s  = word_cnt_r;
        phase_cnt_s = phase_cnt_r;
        done_s      = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (wr_start) begin
                    if (wr_len != LEN_ZERO) begin
                        state_s     = S_PRE;
                        word_cnt_s  = wr_len;
                        phase_cnt_s = PRE_LOAD;
                    end else begin
                        // zero-length request completes immediately
                        done_s = 1'b1;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_PRE: begin
                if (wr_abort) begin
                    state_s     = S_POST;
                    phase_cnt_s = POST_LOAD;
                end else if (phase_cnt_r == {PHASE_W{1'b0}}) begin
                    state_s = S_BURST;
                end else begin
                    phase_cnt_s = phase_cnt_r - PHASE_W'(32'd1);
                end
            end
            S_BURST: begin
                if (wr_abort || (word_cnt_r == LEN_ONE)) begin
                    state_s     = S_POST;
                    phase_cnt_s = POST_LOAD;
                    word_cnt_s  = LEN_ZERO;
                end else begin
                    word_cnt_s = word_cnt_r - LEN_ONE;
                end
            end
            S_POST: begin
                if (phase_cnt_r == {PHASE_W{1'b0}}) begin
                    state_s = S_IDLE;
                    done_s  = 1'b1;
                end else begin
                    phase_cnt_s = phase_cnt_r - PHASE_W'(32'd1);
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // Output decode from the next state so registered outputs track state_r
    always_comb begin
        busy_s      = 1'b0;
        rd_en_s     = 1'b0;
        dqs_oe_n_s  = 1'b1;
        dqs_rst_n_s = 1'b0;
        dq_oe_n_s   = 1'b1;
        case (state_s)
            S_IDLE: begin
                busy_s = 1'b0;
            end
            S_PRE, S_POST: begin
                busy_s     = 1'b1;
                dqs_oe_n_s = 1'b0;
                dq_oe_n_s  = 1'b0;
            end
            S_BURST: begin
                busy_s      = 1'b1;
                rd_en_s     = 1'b1;
                dqs_oe_n_s  = 1'b0;
                dqs_rst_n_s = 1'b1;
                dq_oe_n_s   = 1'b0;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs; rst0 abandons any burst without done
    always_ff @(posedge clk0) begin
        if (rst0) begin
            state_r     <= S_IDLE;
            word_cnt_r  <= LEN_ZERO;
            phase_cnt_r <= {PHASE_W{1'b0}};
            busy        <= 1'b0;
            done        <= 1'b0;
            wdata_rd_en <= 1'b0;
            dqs_oe_n    <= 1'b1;
            dqs_rst_n   <= 1'b0;
            dq_oe_n     <= 1'b1;
        end else begin
            state_r     <= state_s;
            word_cnt_r  <= word_cnt_s;
            phase_cnt_r <= phase_cnt_s;
            busy        <= busy_s;
            done        <= done_s;
            wdata_rd_en <= rd_en_s;
            dqs_oe_n    <= dqs_oe_n_s;
            dqs_rst_n   <= dqs_rst_n_s;
            dq_oe_n     <= dq_oe_n_s;
        end
    end

`ifdef NAND_WR_BURST_CNT_EN
    // Completed-burst counter, stepped alongside each done pulse, wraps at 16 bits
    always_ff @(posedge clk0) begin
        if (rst0) begin
            burst_cnt <= 16'd0;
        end else if (done_s) begin
            burst_cnt <= burst_cnt + 16'd1;
        end else begin
            burst_cnt <= burst_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_nand_phy_dqs_wr_seq.sv
// Directed self-checking bench for nand_phy_dqs_wr_seq (PRE=POST=2, LEN_W=16).
// Build with NAND_WR_BURST_CNT_EN defined to also check burst_cnt.
module tb_nand_phy_dqs_wr_seq;

    logic        clk0 = 1'b0;
    logic        rst0;
    logic        wr_start;
    logic [15:0] wr_len;
    logic        wr_abort;
    logic        busy, done, wdata_rd_en, dqs_oe_n, dqs_rst_n, dq_oe_n;
`ifdef NAND_WR_BURST_CNT_EN
    logic [15:0] burst_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // output vector order: {busy, done, wdata_rd_en, dqs_oe_n, dqs_rst_n, dq_oe_n}
    localparam logic [5:0] V_IDLE  = 6'b000101;
    localparam logic [5:0] V_DRIVE = 6'b100000;
    localparam logic [5:0] V_BURST = 6'b101010;
    localparam logic [5:0] V_DONE  = 6'b010101;

    nand_phy_dqs_wr_seq #(
        .PRE_CYCLES  (32'd2),
        .POST_CYCLES (32'd2),
        .LEN_W       (32'd16)
    ) dut (
        .clk0        (clk0),
        .rst0        (rst0),
        .wr_start    (wr_start),
        .wr_len      (wr_len),
        .wr_abort    (wr_abort),
        .busy        (busy),
        .done        (done),
        .wdata_rd_en (wdata_rd_en),
        .dqs_oe_n    (dqs_oe_n),
        .dqs_rst_n   (dqs_rst_n),
`ifdef NAND_WR_BURST_CNT_EN
        .burst_cnt   (burst_cnt),
`endif
        .dq_oe_n     (dq_oe_n)
    );

    always #5 clk0 = ~clk0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // advance one clock; observe 1 ns after the edge
    task automatic cyc();
        @(posedge clk0);
        #1;
    endtask

    function automatic logic [5:0] outs();
        return {busy, done, wdata_rd_en, dqs_oe_n, dqs_rst_n, dq_oe_n};
    endfunction

    // expected outputs c cycles after an accepted start of len words, no abort
    function automatic logic [5:0] seq_exp(input int c, input int len);
        if (c >= 1 && c <= 2)             return V_DRIVE;
        else if (c >= 3 && c <= 2 + len)  return V_BURST;
        else if (c >= 3 + len && c <= 4 + len) return V_DRIVE;
        else if (c == 5 + len)            return V_DONE;
        else                              return V_IDLE;
    endfunction

    initial begin
        int rd, dn, bz, donec;
        rst0 = 1'b1; wr_start = 1'b0; wr_len = 16'd0; wr_abort = 1'b0;
        cyc(); cyc();
        rst0 = 1'b0;
        check("reset_outs", 32'(outs()), 32'(V_IDLE));
`ifdef NAND_WR_BURST_CNT_EN
        check("reset_cnt", 32'(burst_cnt), 32'd0);
`endif

        // 1: len=4 burst, full cycle-by-cycle profile
        wr_len = 16'd4; wr_start = 1'b1; rd = 0;
        for (int c = 1; c <= 10; c++) begin
            cyc();
            wr_start = 1'b0;
            check($sformatf("t1_c%0d", c), 32'(outs()), 32'(seq_exp(c, 4)));
            if (wdata_rd_en) rd++;
        end
        check("t1_rd_cnt", 32'(rd), 32'd4);

        // 2: zero-length request
        wr_len = 16'd0; wr_start = 1'b1;
        cyc();
        wr_start = 1'b0;
        check("t2_c1", 32'(outs()), 32'(V_DONE));
        cyc();
        check("t2_c2", 32'(outs()), 32'(V_IDLE));

        // 3: len=10, abort during 3rd BURST cycle
        wr_len = 16'd10; wr_start = 1'b1; rd = 0; dn = 0; bz = 0; donec = 0;
        for (int c = 1; c <= 12; c++) begin
            cyc();
            wr_start = 1'b0;
            wr_abort = (c == 5);
            if (wdata_rd_en) rd++;
            if (busy) bz++;
            if (done) begin dn++; donec = c; end
        end
        wr_abort = 1'b0;
        check("t3_rd_cnt", 32'(rd), 32'd3);
        check("t3_busy_cnt", 32'(bz), 32'd7);
        check("t3_done_cnt", 32'(dn), 32'd1);
        check("t3_done_cyc", 32'(donec), 32'd8);

        // 4: second start during BURST of len=5 is ignored
        wr_len = 16'd5; wr_start = 1'b1; rd = 0; dn = 0;
        for (int c = 1; c <= 12; c++) begin
            cyc();
            check($sformatf("t4_c%0d", c), 32'(outs()), 32'(seq_exp(c, 5)));
            if (wdata_rd_en) rd++;
            if (done) dn++;
            wr_start = (c == 4);
            wr_len = (c == 4) ? 16'd3 : 16'd5;
        end
        wr_start = 1'b0;
        check("t4_rd_cnt", 32'(rd), 32'd5);
        check("t4_done_cnt", 32'(dn), 32'd1);

        // 5: reset in BURST of len=8
        wr_len = 16'd8; wr_start = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            cyc();
            wr_start = 1'b0;
        end
        check("t5_in_burst", 32'(outs()), 32'(V_BURST));
        rst0 = 1'b1;
        cyc();
        rst0 = 1'b0;
        check("t5_rst_outs", 32'(outs()), 32'(V_IDLE));
`ifdef NAND_WR_BURST_CNT_EN
        check("t5_rst_cnt", 32'(burst_cnt), 32'd0);
`endif
        dn = 0;
        for (int c = 1; c <= 3; c++) begin
            cyc();
            if (done || busy) dn++;
        end
        check("t5_quiet", 32'(dn), 32'd0);
        wr_len = 16'd1; wr_start = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            cyc();
            wr_start = 1'b0;
            check($sformatf("t5_new_c%0d", c), 32'(outs()), 32'(seq_exp(c, 1)));
        end

`ifdef NAND_WR_BURST_CNT_EN
        // 6: bursts len 1 (above), 0, 2 -> three completions
        check("t6_cnt_after1", 32'(burst_cnt), 32'd1);
        wr_len = 16'd0; wr_start = 1'b1;
        cyc();
        wr_start = 1'b0;
        cyc();
        check("t6_cnt_after0", 32'(burst_cnt), 32'd2);
        wr_len = 16'd2; wr_start = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            cyc();
            wr_start = 1'b0;
        end
        check("t6_cnt_after2", 32'(burst_cnt), 32'd3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
